// File: rtl/fetch_pc_unit_pkg.sv
// rtl/fetch_pc_unit_pkg.sv - shared encodings for the fetch/PC unit, control and COP0 blocks
package fetch_pc_unit_pkg;

   localparam logic [2:0] ORIGPC_PC4  = 3'b000;
   localparam logic [2:0] ORIGPC_BEQ  = 3'b001;
   localparam logic [2:0] ORIGPC_JUMP = 3'b010;
   localparam logic [2:0] ORIGPC_REG  = 3'b011;
   localparam logic [2:0] ORIGPC_ERET = 3'b100;
   localparam logic [2:0] ORIGPC_BNE  = 3'b101;
   localparam logic [2:0] ORIGPC_BC1T = 3'b110;
   localparam logic [2:0] ORIGPC_BC1F = 3'b111;

   localparam logic [1:0] FAULT_NONE     = 2'b00;
   localparam logic [1:0] FAULT_TIMEOUT  = 2'b01;
   localparam logic [1:0] FAULT_MISALIGN = 2'b10;

   localparam logic [31:0] KTEXT_DEFAULT = 32'h8000_0180;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_HOLD  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// rtl/fetch_pc_unit_next_pc_calc.sv - combinational next-PC select and alignment check
module fetch_pc_unit_next_pc_calc
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter bit          ALIGN_CHECK = 1'b1
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [2:0]        orig_pc_i,
   input  logic              zero_i,
   input  logic              flag_i,
   input  logic [31:0]       imm_ext_i,
   input  logic [25:0]       jump_index_i,
   input  logic [ADDR_W-1:0] reg_target_i,
   input  logic [ADDR_W-1:0] eret_target_i,
   output logic [ADDR_W-1:0] pc4_o,
   output logic [ADDR_W-1:0] next_pc_o,
   output logic              misaligned_o
);

   logic [ADDR_W-1:0] pc4;
   logic [31:0]       imm_sh;
   logic [ADDR_W-1:0] branch_tgt;
   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] target;

   always_comb begin
      pc4        = pc_i + ADDR_W'(4);
      imm_sh     = imm_ext_i << 2;
      branch_tgt = pc4 + imm_sh[ADDR_W-1:0];
      jump_tgt   = {pc4[ADDR_W-1:28], jump_index_i, 2'b00};
      case (orig_pc_i)
         ORIGPC_BEQ:  target = zero_i  ? branch_tgt : pc4;
         ORIGPC_BNE:  target = !zero_i ? branch_tgt : pc4;
         ORIGPC_BC1T: target = flag_i  ? branch_tgt : pc4;
         ORIGPC_BC1F: target = !flag_i ? branch_tgt : pc4;
         ORIGPC_JUMP: target = jump_tgt;
         ORIGPC_REG:  target = reg_target_i;
         ORIGPC_ERET: target = eret_target_i;
         default:     target = pc4;
      endcase
      // Without alignment checking the low bits are silently dropped instead of faulting.
      misaligned_o = ALIGN_CHECK && (target[1:0] != 2'b00);
      next_pc_o    = ALIGN_CHECK ? target : {target[ADDR_W-1:2], 2'b00};
      pc4_o        = pc4;
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - handshaked PC/instruction-fetch engine with timeout and kernel redirect
module fetch_pc_unit
   import fetch_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W       = 32,
   parameter logic [31:0] KTEXT_VECTOR = KTEXT_DEFAULT,
   parameter int unsigned TIMEOUT      = 16,
   parameter bit          ALIGN_CHECK  = 1'b1
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [ADDR_W-1:0] iInitialPC,
   input  logic              iAdvance,
   input  logic [2:0]        iOrigPC,
   input  logic              iZero,
   input  logic              iFlag,
   input  logic [31:0]       iImmExt,
   input  logic [25:0]       iJumpIndex,
   input  logic [ADDR_W-1:0] iRegTarget,
   input  logic [ADDR_W-1:0] iEretTarget,
   input  logic              iExcOccurred,
   output logic              oIReq,
   output logic [ADDR_W-1:0] oIAddr,
   input  logic              iIAck,
   input  logic [31:0]       iIData,
   output logic [ADDR_W-1:0] oPC,
   output logic [ADDR_W-1:0] oPC4,
   output logic [31:0]       oInstr,
   output logic              oInstrValid,
   output logic [ADDR_W-1:0] oEPC,
   output logic              oFault,
   output logic [1:0]        oFaultCode
);

   localparam logic [ADDR_W-1:0] KTEXT    = KTEXT_VECTOR[ADDR_W-1:0];
   localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] epc_q, epc_d;
   logic [31:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              fault_q, fault_d;
   logic [1:0]        code_q, code_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              req_en_q, req_en_d;

   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] next_pc;
   logic              misaligned;

   fetch_pc_unit_next_pc_calc #(
      .ADDR_W      (ADDR_W),
      .ALIGN_CHECK (ALIGN_CHECK)
   ) u_next_pc_calc (
      .pc_i          (pc_q),
      .orig_pc_i     (iOrigPC),
      .zero_i        (iZero),
      .flag_i        (iFlag),
      .imm_ext_i     (iImmExt),
      .jump_index_i  (iJumpIndex),
      .reg_target_i  (iRegTarget),
      .eret_target_i (iEretTarget),
      .pc4_o         (pc4),
      .next_pc_o     (next_pc),
      .misaligned_o  (misaligned)
   );

   // req_en_q keeps oIReq low for the first cycle after reset so a stale ack is dropped.
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q  <= ST_FETCH;
         pc_q     <= iInitialPC;
         epc_q    <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         fault_q  <= 1'b0;
         code_q   <= FAULT_NONE;
         cnt_q    <= '0;
         req_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         epc_q    <= epc_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         fault_q  <= fault_d;
         code_q   <= code_d;
         cnt_q    <= cnt_d;
         req_en_q <= req_en_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      epc_d    = epc_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      fault_d  = 1'b0;
      code_d   = code_q;
      cnt_d    = cnt_q;
      req_en_d = 1'b1;
      case (state_q)
         ST_FETCH: begin
            if (req_en_q) begin
               if (iIAck) begin
                  instr_d = iIData;
                  valid_d = 1'b1;
                  cnt_d   = '0;
                  state_d = ST_HOLD;
               end else if (cnt_q == TMO_LAST) begin
                  pc_d    = KTEXT;
                  epc_d   = pc_q;
                  fault_d = 1'b1;
                  code_d  = FAULT_TIMEOUT;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         ST_HOLD: begin
            if (iExcOccurred) begin
               epc_d   = pc_q;
               pc_d    = KTEXT;
               valid_d = 1'b0;
               state_d = ST_FETCH;
            end else if (iAdvance) begin
               valid_d = 1'b0;
               state_d = ST_FETCH;
               if (misaligned) begin
                  epc_d   = next_pc;
                  pc_d    = KTEXT;
                  fault_d = 1'b1;
                  code_d  = FAULT_MISALIGN;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   always_comb begin
      oIReq       = (state_q == ST_FETCH) && req_en_q;
      oIAddr      = pc_q;
      oPC         = pc_q;
      oPC4        = pc4;
      oInstr      = instr_q;
      oInstrValid = valid_q;
      oEPC        = epc_q;
      oFault      = fault_q;
      oFaultCode  = code_q;
   end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - self-checking bench for fetch_pc_unit with directed and random steps
module tb_fetch_pc_unit;

   localparam logic [31:0] KV = 32'h8000_0180;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] iInitialPC;
   logic        iAdvance;
   logic [2:0]  iOrigPC;
   logic        iZero;
   logic        iFlag;
   logic [31:0] iImmExt;
   logic [25:0] iJumpIndex;
   logic [31:0] iRegTarget;
   logic [31:0] iEretTarget;
   logic        iExcOccurred;
   logic        oIReq;
   logic [31:0] oIAddr;
   logic        iIAck;
   logic [31:0] iIData;
   logic [31:0] oPC;
   logic [31:0] oPC4;
   logic [31:0] oInstr;
   logic        oInstrValid;
   logic [31:0] oEPC;
   logic        oFault;
   logic [1:0]  oFaultCode;

   int ncmp = 0;
   int nfail = 0;

   fetch_pc_unit #(
      .ADDR_W       (32),
      .KTEXT_VECTOR (KV),
      .TIMEOUT      (16),
      .ALIGN_CHECK  (1'b1)
   ) dut (
      .iCLK         (clk),
      .iRST_N       (rst_n),
      .iInitialPC   (iInitialPC),
      .iAdvance     (iAdvance),
      .iOrigPC      (iOrigPC),
      .iZero        (iZero),
      .iFlag        (iFlag),
      .iImmExt      (iImmExt),
      .iJumpIndex   (iJumpIndex),
      .iRegTarget   (iRegTarget),
      .iEretTarget  (iEretTarget),
      .iExcOccurred (iExcOccurred),
      .oIReq        (oIReq),
      .oIAddr       (oIAddr),
      .iIAck        (iIAck),
      .iIData       (iIData),
      .oPC          (oPC),
      .oPC4         (oPC4),
      .oInstr       (oInstr),
      .oInstrValid  (oInstrValid),
      .oEPC         (oEPC),
      .oFault       (oFault),
      .oFaultCode   (oFaultCode)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference next-PC, written from the branch/jump rules with plain arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [2:0] sel,
                                            input logic z, input logic f, input logic [31:0] imm,
                                            input logic [25:0] idx, input logic [31:0] rt,
                                            input logic [31:0] et);
      logic [31:0] p4;
      logic [31:0] br;
      p4 = pc + 32'd4;
      br = p4 + imm * 32'd4;
      case (sel)
         3'd1:    return z  ? br : p4;
         3'd5:    return !z ? br : p4;
         3'd6:    return f  ? br : p4;
         3'd7:    return !f ? br : p4;
         3'd2:    return (p4 & 32'hF000_0000) | (32'(idx) * 32'd4);
         3'd3:    return rt;
         3'd4:    return et;
         default: return p4;
      endcase
   endfunction

   // In FETCH at entry: withhold ack for lat cycles (with ignored noise on advance/exc), then ack.
   task automatic fetch(input int lat, input logic [31:0] data, input logic [31:0] pc, input string tag);
      check({tag, "_req"}, {31'd0, oIReq}, 32'd1);
      check({tag, "_addr"}, oIAddr, pc);
      for (int i = 0; i < lat; i++) begin
         iAdvance = 1'($urandom_range(0, 1));
         iExcOccurred = 1'($urandom_range(0, 1));
         tick();
      end
      iIAck = 1'b1;
      iIData = data;
      tick();
      iIAck = 1'b0;
      iAdvance = 1'b0;
      iExcOccurred = 1'b0;
      check({tag, "_valid"}, {31'd0, oInstrValid}, 32'd1);
      check({tag, "_instr"}, oInstr, data);
      check({tag, "_pc"}, oPC, pc);
      check({tag, "_pc4"}, oPC4, pc + 32'd4);
   endtask

   task automatic advance(input logic [2:0] sel, input logic z, input logic f, input logic [31:0] imm,
                          input logic [25:0] idx, input logic [31:0] rt, input logic [31:0] et,
                          input logic exc);
      iOrigPC = sel; iZero = z; iFlag = f; iImmExt = imm; iJumpIndex = idx;
      iRegTarget = rt; iEretTarget = et;
      iAdvance = 1'b1;
      iExcOccurred = exc;
      tick();
      iAdvance = 1'b0;
      iExcOccurred = 1'b0;
   endtask

   logic [31:0] exp_pc, exp_epc, nxt, data;
   logic [1:0]  exp_code;
   logic [2:0]  sel;
   logic        z, f, exc;
   logic [31:0] imm, rt, et;
   logic [25:0] idx;

   initial begin
      rst_n = 1'b0; iInitialPC = 32'h0040_0000; iAdvance = 1'b0; iOrigPC = 3'd0;
      iZero = 1'b0; iFlag = 1'b0; iImmExt = '0; iJumpIndex = '0; iRegTarget = '0;
      iEretTarget = '0; iExcOccurred = 1'b0; iIAck = 1'b0; iIData = '0;

      // Reset and first fetch, ack on the third request cycle.
      tick();
      rst_n = 1'b1;
      check("rst_req", {31'd0, oIReq}, 32'd0);
      check("rst_valid", {31'd0, oInstrValid}, 32'd0);
      check("rst_instr", oInstr, 32'd0);
      check("rst_epc", oEPC, 32'd0);
      check("rst_fault", {31'd0, oFault}, 32'd0);
      check("rst_code", {30'd0, oFaultCode}, 32'd0);
      check("rst_addr", oIAddr, 32'h0040_0000);
      tick();
      fetch(2, 32'h2008_0005, 32'h0040_0000, "first");

      // beq taken / not taken from PC 0x0040_0010.
      advance(3'b011, 1'b0, 1'b0, '0, '0, 32'h0040_0010, '0, 1'b0);
      fetch(0, 32'h1111_0001, 32'h0040_0010, "to10");
      advance(3'b001, 1'b1, 1'b0, 32'hFFFF_FFFE, '0, '0, '0, 1'b0);
      check("beq_taken", oIAddr, 32'h0040_000C);
      fetch(1, 32'h1111_0002, 32'h0040_000C, "beqT");
      advance(3'b011, 1'b0, 1'b0, '0, '0, 32'h0040_0010, '0, 1'b0);
      fetch(0, 32'h1111_0003, 32'h0040_0010, "to10b");
      advance(3'b001, 1'b0, 1'b0, 32'hFFFF_FFFE, '0, '0, '0, 1'b0);
      check("beq_not_taken", oIAddr, 32'h0040_0014);
      fetch(0, 32'h1111_0004, 32'h0040_0014, "beqN");

      // Hold keeps everything steady without advance.
      tick(); tick();
      check("hold_valid", {31'd0, oInstrValid}, 32'd1);
      check("hold_req", {31'd0, oIReq}, 32'd0);
      check("hold_instr", oInstr, 32'h1111_0004);

      // Jump from 0x0040_0000.
      advance(3'b011, 1'b0, 1'b0, '0, '0, 32'h0040_0000, '0, 1'b0);
      fetch(0, 32'h1111_0005, 32'h0040_0000, "to00");
      advance(3'b010, 1'b0, 1'b0, '0, 26'h010_0008, '0, '0, 1'b0);
      check("jump", oIAddr, 32'h0040_0020);

      // Bus timeout at 0x0040_0020: sixteen unacknowledged request cycles.
      for (int i = 0; i < 15; i++) tick();
      check("tmo_before", {31'd0, oFault}, 32'd0);
      tick();
      check("tmo_fault", {31'd0, oFault}, 32'd1);
      check("tmo_code", {30'd0, oFaultCode}, 32'd1);
      check("tmo_addr", oIAddr, KV);
      check("tmo_epc", oEPC, 32'h0040_0020);
      tick();
      check("tmo_pulse", {31'd0, oFault}, 32'd0);
      check("tmo_code_hold", {30'd0, oFaultCode}, 32'd1);
      fetch(0, 32'h1111_0006, KV, "ktext");

      // Exception beats advance.
      advance(3'b011, 1'b0, 1'b0, '0, '0, 32'h0040_0008, '0, 1'b0);
      fetch(0, 32'h1111_0007, 32'h0040_0008, "to08");
      advance(3'b000, 1'b0, 1'b0, '0, '0, '0, '0, 1'b1);
      check("exc_epc", oEPC, 32'h0040_0008);
      check("exc_addr", oIAddr, KV);
      check("exc_nofault", {31'd0, oFault}, 32'd0);
      check("exc_valid", {31'd0, oInstrValid}, 32'd0);
      fetch(0, 32'h1111_0008, KV, "exck");

      // Misaligned register target.
      advance(3'b011, 1'b0, 1'b0, '0, '0, 32'h0040_0002, '0, 1'b0);
      check("mis_fault", {31'd0, oFault}, 32'd1);
      check("mis_code", {30'd0, oFaultCode}, 32'd2);
      check("mis_epc", oEPC, 32'h0040_0002);
      check("mis_addr", oIAddr, KV);

      // Reset mid-FETCH with a late ack in the release cycle.
      tick();
      rst_n = 1'b0;
      iInitialPC = 32'h0040_0100;
      tick();
      rst_n = 1'b1;
      iIAck = 1'b1;
      iIData = 32'hDEAD_BEEF;
      check("rst2_req", {31'd0, oIReq}, 32'd0);
      tick();
      iIAck = 1'b0;
      check("rst2_valid", {31'd0, oInstrValid}, 32'd0);
      check("rst2_instr", oInstr, 32'd0);
      check("rst2_code", {30'd0, oFaultCode}, 32'd0);
      fetch(1, 32'h1111_0009, 32'h0040_0100, "refetch");

      // Random steps against the reference model.
      exp_pc = 32'h0040_0100;
      exp_epc = 32'd0;
      exp_code = 2'd0;
      for (int n = 0; n < 60; n++) begin
         sel = 3'($urandom_range(0, 7));
         z = 1'($urandom_range(0, 1));
         f = 1'($urandom_range(0, 1));
         imm = $urandom;
         idx = 26'($urandom);
         rt = $urandom;
         et = $urandom;
         if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
         if ($urandom_range(0, 3) != 0) et[1:0] = 2'b00;
         exc = ($urandom_range(0, 7) == 0);
         for (int h = $urandom_range(0, 2); h > 0; h--) tick();
         advance(sel, z, f, imm, idx, rt, et, exc);
         if (exc) begin
            exp_epc = exp_pc;
            exp_pc = KV;
            check("rnd_exc_fault", {31'd0, oFault}, 32'd0);
         end else begin
            nxt = ref_next(exp_pc, sel, z, f, imm, idx, rt, et);
            if (nxt % 4 != 0) begin
               exp_epc = nxt;
               exp_pc = KV;
               exp_code = 2'd2;
               check("rnd_mis_fault", {31'd0, oFault}, 32'd1);
            end else begin
               exp_pc = nxt;
               check("rnd_fault", {31'd0, oFault}, 32'd0);
            end
         end
         check("rnd_epc", oEPC, exp_epc);
         check("rnd_code", {30'd0, oFaultCode}, {30'd0, exp_code});
         data = $urandom;
         fetch($urandom_range(0, 6), data, exp_pc, "rnd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
